// File: rtl/fpu_normalize_if.sv
// Handshake and data bundle between the FPU compute stage, the normalize stage and the consumer.
// The master modport is the side that drives the operands and out_ready.
interface fpu_normalize_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [47:0] in_mantissa;
    logic [1:0]  in_operator;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    modport master (
        output in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );
endinterface

// File: rtl/fpu_normalize.sv
// Post-compute FPU stage: sign-magnitude fixup, one-bit-per-cycle normalize, rounding and
// overflow/underflow resolution into a packed single-precision word.
//
// state | meaning
// IDLE  | waiting for an operand word, in_ready high
// NORM  | shifting w left until w[47] is set
// ROUND | rounding and final result selection
// DONE  | result held until out_ready
module fpu_normalize #(
    parameter bit ROUND_RNE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    fpu_normalize_if.slave bus
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [47:0]        w;
    logic signed [9:0]  e;
    logic               sign;
    logic               zero;
    logic               is_mul;

    logic [31:0]        result;
    logic               overflow;
    logic               underflow;

    logic               accept;
    logic [47:0]        w_load;
    logic signed [9:0]  e_load;
    logic               sign_load;
    logic               zero_load;

    logic [22:0]        frac;
    logic               guard;
    logic               sticky;
    logic               lsb;
    logic               round_up;
    logic [23:0]        frac_sum;
    logic               carry;
    logic signed [9:0]  e_rnd;
    logic [31:0]        result_nxt;
    logic               overflow_nxt;
    logic               underflow_nxt;

    assign accept = bus.in_valid && (state == IDLE);

    // Add/sub arrive as 48-bit two's complement; fold negatives into sign-magnitude here.
    always_comb begin
        w_load    = bus.in_mantissa;
        sign_load = bus.in_sign;
        e_load    = $signed({2'b00, bus.in_exponent}) + 10'sd24;
        if (bus.in_operator == 2'b10) begin
            e_load = $signed({2'b00, bus.in_exponent}) + 10'sd1;
        end else if (bus.in_mantissa[47]) begin
            w_load    = -bus.in_mantissa;
            sign_load = ~bus.in_sign;
        end
        zero_load = (w_load == 48'd0) || (bus.in_operator == 2'b11);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_load ? ROUND : NORM;
            NORM:    if (w[47]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready      = (state == IDLE);
        bus.out_valid     = (state == DONE);
        bus.out_result    = result;
        bus.out_overflow  = overflow;
        bus.out_underflow = underflow;
    end

    assign frac     = w[46:24];
    assign guard    = w[23];
    assign sticky   = |w[22:0];
    assign lsb      = w[24];
    assign round_up = ROUND_RNE && guard && (sticky || lsb);
    assign frac_sum = {1'b0, frac} + {23'd0, round_up};
    assign carry    = frac_sum[23];
    assign e_rnd    = e + $signed({9'd0, carry});

    // Exponent checks happen after the rounding carry so 0x7FFFFF+1 at e=254 saturates.
    always_comb begin
        result_nxt    = {sign, e_rnd[7:0], frac_sum[22:0]};
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (zero) begin
            result_nxt = is_mul ? {sign, 31'd0} : 32'd0;
        end else if (e_rnd >= 10'sd255) begin
            result_nxt   = {sign, 8'hFF, 23'd0};
            overflow_nxt = 1'b1;
        end else if (e_rnd <= 10'sd0) begin
            result_nxt    = {sign, 31'd0};
            underflow_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w         <= 48'd0;
            e         <= 10'sd0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            is_mul    <= 1'b0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        w      <= w_load;
                        e      <= e_load;
                        sign   <= sign_load;
                        zero   <= zero_load;
                        is_mul <= (bus.in_operator == 2'b10);
                    end
                end
                NORM: begin
                    if (!w[47]) begin
                        w <= w << 1;
                        e <= e - 10'sd1;
                    end
                end
                ROUND: begin
                    result    <= result_nxt;
                    overflow  <= overflow_nxt;
                    underflow <= underflow_nxt;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        result    <= 32'd0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpu_normalize.md
Name: fpu_normalize

Overview:
- Post-compute stage of the FPU pipeline. It takes the raw sign, biased exponent, 48-bit mantissa and operator from the compute stage and produces a packed IEEE-754 single-precision result.
- Work done per operation:
  - resolves negative add/sub results to sign-magnitude;
  - normalizes iteratively, one left shift per cycle;
  - rounds (round-to-nearest-even by default);
  - detects overflow and underflow.
- Uses a valid/ready handshake on both sides, so the iterative normalize can stall the compute stage.

Parameters:
- ROUND_RNE, 1, 1 selects round-to-nearest-even; 0 selects truncation (guard/sticky ignored).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept (high only in IDLE)
- in_sign  input  1  sign from compute stage
- in_exponent  input  8  biased exponent. Add/sub: common aligned exponent. Mul: e1+e2-127.
- in_mantissa  input  48  raw result. Add/sub: binary point below bit 23, two's complement over 48 bits. Mul: 2.46 product, point below bit 46.
- in_operator  input  2  00 add, 01 sub, 10 mul, 11 unused
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to zero

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; out_valid=0, out_result=0, out_overflow=0, out_underflow=0, in_ready=1.
  - Internal w (48b) and e (signed 10b) cleared.
- States: IDLE, NORM, ROUND, DONE.
- IDLE, on in_valid && in_ready (edge k):
  - add/sub: if in_mantissa[47]=1, then w=-in_mantissa and sign=~in_sign; else w=in_mantissa, sign=in_sign. Set e=in_exponent+24.
  - mul: w=in_mantissa, sign=in_sign, e=in_exponent+1.
  - If w==0 or in_operator==11, set zero flag and go to ROUND. Otherwise go to NORM.
- NORM:
  - if w[47]=1, go to ROUND;
  - else w<=w<<1 and e<=e-1, stay in NORM.
  - At most 47 shifts.
- ROUND:
  - Fields: frac=w[46:24], guard=w[23], sticky=|w[22:0], lsb=w[24].
  - Round-up condition: ROUND_RNE && guard && (sticky||lsb).
  - {1,frac}+1 carrying out of bit 23 gives frac=0 and e=e+1.
  - Final result selection, in priority order:
    - zero flag: result {0,31'b0} for add/sub/unused; {sign,31'b0} for mul. Flags 0.
    - e>=255: {sign,8'hFF,23'b0}, out_overflow=1.
    - e<=0: {sign,31'b0}, out_underflow=1.
    - otherwise: {sign,e[7:0],frac}.
  - Go to DONE with out_valid=1.
- DONE:
  - outputs stable while out_ready=0;
  - on out_ready=1, out_valid<=0 and go to IDLE.
  - No new accept in the same cycle; one bubble per operation.
- Latency: with N normalize shifts, out_valid rises after edge k+2+N. The zero path gives out_valid after edge k+1.
- Width rule: e is signed 10-bit and must cover the range -47..279 without wrap.
- Flags hold with out_result and clear on handshake.
- rst_n asserted in any state: immediate return to reset values; the in-flight operation is discarded.
- in_* inputs are ignored outside IDLE.

Test Plan:
- Add 1.0+1.0: op=00, exp=127, mant=0x000001000000 -> 23 shifts, out_result=0x40000000, out_valid after edge k+25.
- Sub 1.0-1.5: op=01, sign=0, exp=127, mant=0xFFFFFFC00000 -> out_result=0xBF000000 (-0.5), flags 0.
- Mul 1.5*1.5: op=10, exp=127, mant=0x900000000000 -> N=0, out_result=0x40100000, out_valid after edge k+2.
- Rounding carry: op=10, exp=127, mant=0xFFFFFFFFFFFF -> out_result=0x40800000.
  - Same input with ROUND_RNE=0 -> 0x407FFFFF.
- Overflow/underflow:
  - op=10, exp=254, mant=0x800000000000 -> 0x7F800000, out_overflow=1.
  - op=00, exp=1, mant=0x000000400000 -> 0x00000000, out_underflow=1.
  - op=00, mant=0 -> 0x00000000 after edge k+1.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles -> out_result and out_valid stable, in_ready=0.
  - pulse rst_n low mid-NORM -> out_valid=0, in_ready=1 immediately; the next operation completes correctly.
